divider: RTL

- Multi-cycle radix-2 restoring integer divider for the RV32M extension. Executes DIV, DIVU, REM and REMU.
- Sits in the EX stage beside the multiplier and uses the same hold-until-done handshake: EX holds `is_div` high and stalls until `div_done` pulses.
- Operands are converted to magnitudes, divided iteratively, then sign-corrected.
- RISC-V special cases (divide-by-zero, signed overflow) bypass the iteration.

---
 rtl/divider.sv | 288 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/divider.sv
// divider: multi-cycle radix-2 restoring integer divider for RV32M (DIV, DIVU, REM, REMU).
// EX holds is_div high until the single-cycle div_done pulse.
// Operands are reduced to magnitudes, divided BITS_PER_CYCLE quotient bits per cycle,
// then sign-corrected. Divide-by-zero and signed overflow skip the iteration.
// Optional build macro DIV_RESULT_CACHE_EN: remembers the last completed operation so that
// a matching request (e.g. REM after DIV on the same operands) completes one cycle later.

package divider_pkg;
    // bit0 = unsigned, bit1 = return remainder (div=100, divu=101, rem=110, remu=111)
    typedef logic [2:0] m_funct3_t;
endpackage

module divider #(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            rs1_data,
    input  logic [31:0]            rs2_data,
    input  divider_pkg::m_funct3_t funct3,
    input  logic                   is_div,
    output logic                   div_done,
    output logic [31:0]            div_out
);

    localparam int unsigned NITER = 32 / BITS_PER_CYCLE;
    localparam logic [5:0] CntStep = 6'(BITS_PER_CYCLE);
    // Count value seen during the final ITER cycle.
    localparam logic [5:0] CntLast = 6'((NITER - 1) * BITS_PER_CYCLE);

    typedef enum logic [2:0] {
        StIdle,
        StPrep,
        StIter,
        StFix,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Latched request
    divider_pkg::m_funct3_t funct3_q, funct3_d;
    logic [31:0] rs1_q, rs1_d;
    logic [31:0] rs2_q, rs2_d;

    // Iteration datapath
    logic [31:0] dvsr_q, dvsr_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;

    // Registered outputs
    logic        div_done_q, div_done_d;
    logic [31:0] div_out_q, div_out_d;

    // PREP-stage decode of the latched operands
    logic        signed_op;
    logic        rs1_neg;
    logic        rs2_neg;
    logic [31:0] rs1_mag;
    logic [31:0] rs2_mag;
    logic        div_by_zero;
    logic        overflow;
    logic        special;

    // Combinational unroll of the per-cycle iteration
    logic [31:0] iter_rem;
    logic [31:0] iter_quo;

    logic        cache_hit;

    // One restoring step: shift {rem, quo} left, trial-subtract with 33 bits so that a
    // magnitude of 0x80000000 or an unsigned 0xFFFFFFFF divisor cannot overflow.
    function automatic logic [63:0] div_step(input logic [31:0] rem,
                                             input logic [31:0] quo,
                                             input logic [31:0] dvsr);
        logic [32:0] rem_sh;
        logic [31:0] quo_sh;
        logic [32:0] trial;
        {rem_sh, quo_sh} = {1'b0, rem, quo} << 1;
        trial = rem_sh - {1'b0, dvsr};
        if (rem_sh >= {1'b0, dvsr}) begin
            return {trial[31:0], quo_sh[31:1], 1'b1};
        end
        return {rem_sh[31:0], quo_sh};
    endfunction

    // Operand sign/magnitude and special-case decode
    always_comb begin
        signed_op   = ~funct3_q[0];
        rs1_neg     = signed_op & rs1_q[31];
        rs2_neg     = signed_op & rs2_q[31];
        rs1_mag     = rs1_neg ? (32'd0 - rs1_q) : rs1_q;
        rs2_mag     = rs2_neg ? (32'd0 - rs2_q) : rs2_q;
        div_by_zero = (rs2_q == 32'd0);
        overflow    = signed_op && (rs1_q == 32'h8000_0000) && (rs2_q == 32'hFFFF_FFFF);
        special     = div_by_zero | overflow;
    end

`ifdef DIV_RESULT_CACHE_EN
    logic        cache_valid_q;
    logic [31:0] cache_rs1_q;
    logic [31:0] cache_rs2_q;
    logic        cache_uns_q;
    logic [31:0] cache_quo_q;
    logic [31:0] cache_rem_q;

    // Hit when operands and signedness match the last completed operation
    always_comb begin
        cache_hit = cache_valid_q && (rs1_data == cache_rs1_q) && (rs2_data == cache_rs2_q) &&
                    (funct3[0] == cache_uns_q);
    end

    // Capture every completed operation; aborted ones never reach DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_valid_q <= 1'b0;
            cache_rs1_q   <= '0;
            cache_rs2_q   <= '0;
            cache_uns_q   <= 1'b0;
            cache_quo_q   <= '0;
            cache_rem_q   <= '0;
        end else if (state_q == StDone) begin
            cache_valid_q <= 1'b1;
            cache_rs1_q   <= rs1_q;
            cache_rs2_q   <= rs2_q;
            cache_uns_q   <= funct3_q[0];
            cache_quo_q   <= quo_q;
            cache_rem_q   <= rem_q;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; dropping is_div before DONE abandons the operation
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (is_div) begin
                    state_d = cache_hit ? StDone : StPrep;
                end
            end
            StPrep: begin
                if (!is_div) begin
                    state_d = StIdle;
                end else if (special) begin
                    state_d = StDone;
                end else begin
                    state_d = StIter;
                end
            end
            StIter: begin
                if (!is_div) begin
                    state_d = StIdle;
                end else if (cnt_q == CntLast) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                state_d = is_div ? StDone : StIdle;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM outputs: one-cycle done pulse and registered result select
    always_comb begin
        div_done_d = (state_q == StDone);
        div_out_d  = div_out_q;
        if (state_q == StDone) begin
            div_out_d = funct3_q[1] ? rem_q : quo_q;
        end
    end

    // Datapath next state
    always_comb begin
        funct3_d  = funct3_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        dvsr_d    = dvsr_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;

        iter_rem = rem_q;
        iter_quo = quo_q;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            {iter_rem, iter_quo} = div_step(iter_rem, iter_quo, dvsr_q);
        end

        unique case (state_q)
            StIdle: begin
                if (is_div) begin
                    funct3_d = funct3;
                    rs1_d    = rs1_data;
                    rs2_d    = rs2_data;
`ifdef DIV_RESULT_CACHE_EN
                    if (cache_hit) begin
                        quo_d = cache_quo_q;
                        rem_d = cache_rem_q;
                    end
`endif
                end
            end
            StPrep: begin
                neg_quo_d = rs1_neg ^ rs2_neg;
                neg_rem_d = rs1_neg;
                dvsr_d    = rs2_mag;
                cnt_d     = '0;
                if (div_by_zero) begin
                    quo_d = 32'hFFFF_FFFF;
                    rem_d = rs1_q;
                end else if (overflow) begin
                    quo_d = 32'h8000_0000;
                    rem_d = 32'd0;
                end else begin
                    quo_d = rs1_mag;
                    rem_d = 32'd0;
                end
            end
            StIter: begin
                rem_d = iter_rem;
                quo_d = iter_quo;
                cnt_d = cnt_q + CntStep;
            end
            StFix: begin
                // Quotient sign is the XOR of operand signs; remainder follows the dividend
                quo_d = neg_quo_q ? (32'd0 - quo_q) : quo_q;
                rem_d = neg_rem_q ? (32'd0 - rem_q) : rem_q;
            end
            default: begin
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            funct3_q   <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            dvsr_q     <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_done_q <= 1'b0;
            div_out_q  <= '0;
        end else begin
            funct3_q   <= funct3_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            dvsr_q     <= dvsr_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            div_done_q <= div_done_d;
            div_out_q  <= div_out_d;
        end
    end

    assign div_done = div_done_q;
    assign div_out  = div_out_q;

endmodule
